// File: rtl/ysyx_22050058_ctrl_pkg.sv
// Shared constants and helpers for the pipeline control block: stage indices,
// the stall bus type and the stall-priority / bubble helpers.
package ysyx_22050058_ctrl_pkg;

  localparam int STAGE_PC    = 0;
  localparam int STAGE_IFID  = 1;
  localparam int STAGE_IDEX  = 2;
  localparam int STAGE_EXMEM = 3;
  localparam int STAGE_MEMWB = 4;

  localparam int STALL_BUS_W = 5;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic IS_JUMP       = 1'b1;
  localparam logic NO_JUMP       = 1'b0;

  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  typedef struct packed {
    logic mem_req;
    logic ex_req;
    logic id_req;
    logic if_req;
  } stall_req_t;

  // Deepest requesting stage wins; everything at or before it holds.
  function automatic stall_bus_t stall_of(input stall_req_t req);
    stall_bus_t s;
    s = {STALL_BUS_W{STALL_DISABLE}};
    if (req.mem_req)     s = {5{STALL_ENABLE}};
    else if (req.ex_req) s = 5'b01111;
    else if (req.id_req) s = 5'b00111;
    else if (req.if_req) s = 5'b00011;
    return s;
  endfunction

  // The register just past the highest held one gets a bubble, unless
  // MEM/WB itself holds (nothing downstream to protect).
  function automatic stall_bus_t bubble_of(input stall_bus_t s);
    stall_bus_t b;
    b = '0;
    if (s[STAGE_MEMWB])      b = '0;
    else if (s[STAGE_EXMEM]) b[STAGE_MEMWB] = 1'b1;
    else if (s[STAGE_IDEX])  b[STAGE_EXMEM] = 1'b1;
    else if (s[STAGE_IFID])  b[STAGE_IDEX]  = 1'b1;
    else if (s[STAGE_PC])    b[STAGE_IFID]  = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/ysyx_22050058_satcnt.sv
// Saturating up-counter with synchronous clear; used for the stall and
// redirect performance counters.
module ysyx_22050058_satcnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_22050058_ctrl.sv
// Pipeline control: merges stage stall requests and EX branch resolution into
// hold/bubble vectors and a PC redirect, parking redirects fetch cannot take.
module ysyx_22050058_ctrl
  import ysyx_22050058_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_ifreq_i,
  input  logic              id_stall_idreq_i,
  input  logic              ex_stall_exreq_i,
  input  logic              mem_stall_memreq_i,
  input  logic              ex_isjump_i,
  input  logic [ADDR_W-1:0] ex_jumpaddr_i,
  output logic [4:0]        ctrl_stall_o,
  output logic [4:0]        ctrl_flush_o,
  output logic              ctrl_redirect_valid_o,
  output logic [ADDR_W-1:0] ctrl_redirect_pc_o,
  output logic              ctrl_pending_o,
  output logic [CNT_W-1:0]  ctrl_stall_cnt_o,
  output logic [CNT_W-1:0]  ctrl_flush_cnt_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [0:0]        pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  stall_req_t        req;
  stall_bus_t        stall_raw, flush_raw;
  logic              jump_take;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  assign req = '{mem_req: mem_stall_memreq_i, ex_req: ex_stall_exreq_i,
                 id_req: id_stall_idreq_i, if_req: if_stall_ifreq_i};

  // A jump only counts when the instruction in EX actually moves on.
  assign jump_take = (ex_isjump_i == IS_JUMP) && (stall_raw[STAGE_EXMEM] == STALL_DISABLE);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    stall_raw      = stall_of(req);
    flush_raw      = bubble_of(stall_raw);
    redirect_valid = NO_JUMP;
    redirect_pc    = pend_pc_q;
    pend_d         = pend_q;
    pend_pc_d      = pend_pc_q;

    if (jump_take) begin
      // A new jump takes priority even over a parked one.
      flush_raw[STAGE_IFID] = 1'b1;
      flush_raw[STAGE_IDEX] = 1'b1;
      if (if_stall_ifreq_i) begin
        pend_d    = S_PEND;
        pend_pc_d = ex_jumpaddr_i;
      end else begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_jumpaddr_i;
        pend_d         = S_IDLE;
      end
    end else if (pend_q == S_PEND) begin
      // Whatever fetch returns while parked is wrong-path.
      flush_raw[STAGE_IFID] = 1'b1;
      if (!if_stall_ifreq_i) begin
        redirect_valid = 1'b1;
        pend_d         = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= S_IDLE;
      pend_pc_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Squash beats hold: a bubbled register must not keep its old contents.
  assign ctrl_stall_o          = rst ? '0 : (stall_raw & ~flush_raw);
  assign ctrl_flush_o          = rst ? '0 : flush_raw;
  assign ctrl_redirect_valid_o = rst ? 1'b0 : redirect_valid;
  assign ctrl_redirect_pc_o    = rst ? '0 : (redirect_valid ? redirect_pc : '0);
  assign ctrl_pending_o        = rst ? 1'b0 : pend_q[0];
  assign ctrl_stall_cnt_o      = rst ? '0 : stall_cnt;
  assign ctrl_flush_cnt_o      = rst ? '0 : flush_cnt;

  ysyx_22050058_satcnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_stall_o[STAGE_PC]),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  ysyx_22050058_satcnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_redirect_valid_o),
    .clr (1'b0),
    .cnt (flush_cnt)
  );

  a_no_jump_while_pending : assert property (
    @(posedge clk) disable iff (rst) !((pend_q == S_PEND) && jump_take));

endmodule

// File: tb/tb_ysyx_22050058_ctrl.sv
// Directed bench for ysyx_22050058_ctrl: a table of single-cycle vectors plus
// hand-written park, MEM-stall, saturation and reset sequences.
module tb_ysyx_22050058_ctrl;

  localparam int ADDR_W = 64;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, id_req, ex_req, mem_req, isjump;
  logic [ADDR_W-1:0] jumpaddr;
  logic [4:0]        stall_o, flush_o;
  logic              rv_o, pending_o;
  logic [ADDR_W-1:0] rpc_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ysyx_22050058_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .if_stall_ifreq_i      (if_req),
    .id_stall_idreq_i      (id_req),
    .ex_stall_exreq_i      (ex_req),
    .mem_stall_memreq_i    (mem_req),
    .ex_isjump_i           (isjump),
    .ex_jumpaddr_i         (jumpaddr),
    .ctrl_stall_o          (stall_o),
    .ctrl_flush_o          (flush_o),
    .ctrl_redirect_valid_o (rv_o),
    .ctrl_redirect_pc_o    (rpc_o),
    .ctrl_pending_o        (pending_o),
    .ctrl_stall_cnt_o      (stall_cnt_o),
    .ctrl_flush_cnt_o      (flush_cnt_o)
  );

  typedef struct {
    logic        mem, ex, id, ifr, jmp;
    logic [63:0] addr;
    logic [4:0]  exp_stall, exp_flush;
    logic        exp_rv;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic mem, input logic ex, input logic id, input logic ifr,
                       input logic jmp, input logic [63:0] addr);
    mem_req = mem; ex_req = ex; id_req = id; if_req = ifr; isjump = jmp; jumpaddr = addr;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_sc, exp_fc;
    //         mem ex id if jmp addr                stall     flush     rv pc
    vecs[0]  = '{0, 0, 0, 0, 0, 64'h0,            5'b00000, 5'b00000, 0, 64'h0};
    vecs[1]  = '{1, 0, 1, 0, 0, 64'h0,            5'b11111, 5'b00000, 0, 64'h0};
    vecs[2]  = '{0, 0, 1, 0, 0, 64'h0,            5'b00111, 5'b01000, 0, 64'h0};
    vecs[3]  = '{0, 0, 0, 0, 0, 64'h0,            5'b00000, 5'b00000, 0, 64'h0};
    vecs[4]  = '{0, 1, 0, 0, 0, 64'h0,            5'b01111, 5'b10000, 0, 64'h0};
    vecs[5]  = '{0, 0, 0, 1, 0, 64'h0,            5'b00011, 5'b00100, 0, 64'h0};
    vecs[6]  = '{0, 0, 0, 0, 1, 64'h8000_0040,    5'b00000, 5'b00110, 1, 64'h8000_0040};
    vecs[7]  = '{0, 1, 0, 0, 1, 64'h8000_0080,    5'b01111, 5'b10000, 0, 64'h0};
    vecs[8]  = '{0, 0, 1, 0, 1, 64'h8000_00c0,    5'b00001, 5'b01110, 1, 64'h8000_00c0};
    vecs[9]  = '{1, 0, 0, 0, 1, 64'h8000_0100,    5'b11111, 5'b00000, 0, 64'h0};
    vecs[10] = '{0, 0, 0, 0, 0, 64'h0,            5'b00000, 5'b00000, 0, 64'h0};

    // Reset: outputs forced low even with a request present.
    rst = 1'b1;
    drive(1, 0, 0, 1, 1, 64'h1234);
    #2;
    check("rst_stall", {59'd0, stall_o}, 64'd0);
    check("rst_flush", {59'd0, flush_o}, 64'd0);
    check("rst_rv", {63'd0, rv_o}, 64'd0);
    check("rst_cnt", {32'd0, stall_cnt_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    exp_sc = 0;
    exp_fc = 0;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].mem, vecs[i].ex, vecs[i].id, vecs[i].ifr, vecs[i].jmp, vecs[i].addr);
      #1;
      check($sformatf("vec%0d_stall", i), {59'd0, stall_o}, {59'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_flush", i), {59'd0, flush_o}, {59'd0, vecs[i].exp_flush});
      check($sformatf("vec%0d_rv", i), {63'd0, rv_o}, {63'd0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) check($sformatf("vec%0d_pc", i), rpc_o, vecs[i].exp_pc);
      check($sformatf("vec%0d_pend", i), {63'd0, pending_o}, 64'd0);
      exp_sc += int'(vecs[i].exp_stall[0]);
      exp_fc += int'(vecs[i].exp_rv);
      @(negedge clk);
    end
    #1;
    check("tbl_stall_cnt", {32'd0, stall_cnt_o}, 64'(exp_sc));
    check("tbl_flush_cnt", {32'd0, flush_cnt_o}, 64'(exp_fc));

    // Single redirect with fetch idle.
    reset_pulse();
    drive(0, 0, 0, 0, 1, 64'h8000_0040);
    #1;
    check("jmp_rv", {63'd0, rv_o}, 64'd1);
    check("jmp_pc", rpc_o, 64'h8000_0040);
    check("jmp_flush", {59'd0, flush_o}, 64'b00110);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 64'h0);
    #1;
    check("jmp_flush_cnt", {32'd0, flush_cnt_o}, 64'd1);
    check("jmp_rv_after", {63'd0, rv_o}, 64'd0);

    // Park path: fetch busy at the jump and for three more cycles.
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 64'h8000_0040);
    #1;
    check("park_entry_rv", {63'd0, rv_o}, 64'd0);
    check("park_entry_flush", {59'd0, flush_o}, 64'b00110);
    check("park_entry_pend", {63'd0, pending_o}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 64'h0);
      #1;
      check($sformatf("park%0d_pend", c), {63'd0, pending_o}, 64'd1);
      check($sformatf("park%0d_flush1", c), {63'd0, flush_o[1]}, 64'd1);
      check($sformatf("park%0d_rv", c), {63'd0, rv_o}, 64'd0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 64'h0);
    #1;
    check("park_deliver_rv", {63'd0, rv_o}, 64'd1);
    check("park_deliver_pc", rpc_o, 64'h8000_0040);
    check("park_deliver_flush", {59'd0, flush_o}, 64'b00010);
    @(negedge clk);
    #1;
    check("park_done_pend", {63'd0, pending_o}, 64'd0);
    check("park_done_rv", {63'd0, rv_o}, 64'd0);
    check("park_flush_cnt", {32'd0, flush_cnt_o}, 64'd2);

    // Jump held in EX behind a MEM stall.
    reset_pulse();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 0, 0, 1, 64'h8000_0100);
      #1;
      check($sformatf("memjmp%0d_rv", c), {63'd0, rv_o}, 64'd0);
      check($sformatf("memjmp%0d_flush", c), {59'd0, flush_o}, 64'd0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 1, 64'h8000_0100);
    #1;
    check("memjmp_rel_rv", {63'd0, rv_o}, 64'd1);
    check("memjmp_rel_pc", rpc_o, 64'h8000_0100);
    check("memjmp_rel_flush", {59'd0, flush_o}, 64'b00110);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 64'h0);
    #1;
    check("memjmp_after_rv", {63'd0, rv_o}, 64'd0);
    check("memjmp_stall_cnt", {32'd0, stall_cnt_o}, 64'd2);
    check("memjmp_flush_cnt", {32'd0, flush_cnt_o}, 64'd1);

    // Saturation: preload near all-ones, then three stall cycles.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 64'h0);
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.u_stall_cnt.cnt_q;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 64'h0);
    #1;
    check("sat_stall_cnt", {32'd0, stall_cnt_o}, 64'hFFFF_FFFF);

    // Asynchronous reset while a redirect is parked.
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 64'h8000_0040);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 64'h0);
    #1;
    check("rstpend_pend_before", {63'd0, pending_o}, 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rstpend_pend", {63'd0, pending_o}, 64'd0);
    check("rstpend_stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
    check("rstpend_flush_cnt", {32'd0, flush_cnt_o}, 64'd0);
    check("rstpend_flush", {59'd0, flush_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 64'h0);
    #1;
    check("rstpend_after_rv", {63'd0, rv_o}, 64'd0);
    check("rstpend_after_pend", {63'd0, pending_o}, 64'd0);
    check("rstpend_after_scnt", {32'd0, stall_cnt_o}, 64'd0);
    check("rstpend_after_fcnt", {32'd0, flush_cnt_o}, 64'd0);
    @(negedge clk);
    #1;
    check("rstpend_later_rv", {63'd0, rv_o}, 64'd0);
    check("rstpend_later_flush", {59'd0, flush_o}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
